// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: holds one decoded instruction and presents forwarded ALU operands.
// Latency: 1 cycle from capture to out_valid when no hazard is present.
// Backpressure: in_ready drops while the entry is held by !out_ready or a load-use stall.
module alu_issue_stage #(
   parameter int XLEN  = 32,
   parameter int RADDR = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [XLEN-1:0]  in_pc,
   input  logic [RADDR-1:0] in_rs1_addr,
   input  logic [RADDR-1:0] in_rs2_addr,
   input  logic [XLEN-1:0]  in_rs1_data,
   input  logic [XLEN-1:0]  in_rs2_data,
   input  logic [XLEN-1:0]  in_imm,
   input  logic             in_src_a,
   input  logic             in_src_b,
   input  logic [3:0]       in_alu_ctrl,
   input  logic [RADDR-1:0] in_rd_addr,
   input  logic             in_reg_write,
   input  logic             exm_valid,
   input  logic             exm_reg_write,
   input  logic             exm_is_load,
   input  logic [RADDR-1:0] exm_rd_addr,
   input  logic [XLEN-1:0]  exm_result,
   input  logic             wb_valid,
   input  logic             wb_reg_write,
   input  logic [RADDR-1:0] wb_rd_addr,
   input  logic [XLEN-1:0]  wb_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_op_a,
   output logic [XLEN-1:0]  out_op_b,
   output logic [3:0]       out_alu_ctrl,
   output logic [XLEN-1:0]  out_store_data,
   output logic [XLEN-1:0]  out_pc,
   output logic [RADDR-1:0] out_rd_addr,
   output logic             out_reg_write,
   output logic             out_illegal
);

   typedef struct packed {
      logic [XLEN-1:0]  pc;
      logic [XLEN-1:0]  rs1_data;
      logic [XLEN-1:0]  rs2_data;
      logic [XLEN-1:0]  imm;
      logic [RADDR-1:0] rs1_addr;
      logic [RADDR-1:0] rs2_addr;
      logic [RADDR-1:0] rd_addr;
      logic             src_a;
      logic             src_b;
      logic [3:0]       alu_ctrl;
      logic             reg_write;
      logic             illegal;
   } entry_t;

   entry_t ent;
   entry_t cap;
   logic   v;

   logic wb_wr, exm_wr;
   logic cap_wb1, cap_wb2, hold_wb1, hold_wb2;
   logic fwd1, fwd2;
   logic load_hazard, capture, retire, code_ok;
   logic [XLEN-1:0] rs1_eff, rs2_eff;

   function automatic logic legal_code(input logic [3:0] c);
      case (c)
         4'b0000, 4'b1000, 4'b0001, 4'b0010, 4'b0011,
         4'b0100, 4'b0101, 4'b1101, 4'b0110, 4'b0111: legal_code = 1'b1;
         default:                                      legal_code = 1'b0;
      endcase
   endfunction

   // x0 never matches a bypass source, so all match terms exclude address 0.
   assign wb_wr    = wb_valid && wb_reg_write;
   assign exm_wr   = exm_valid && exm_reg_write;
   assign cap_wb1  = wb_wr && (in_rs1_addr != '0) && (wb_rd_addr == in_rs1_addr);
   assign cap_wb2  = wb_wr && (in_rs2_addr != '0) && (wb_rd_addr == in_rs2_addr);
   assign hold_wb1 = wb_wr && (ent.rs1_addr != '0) && (wb_rd_addr == ent.rs1_addr);
   assign hold_wb2 = wb_wr && (ent.rs2_addr != '0) && (wb_rd_addr == ent.rs2_addr);
   assign fwd1     = exm_wr && (ent.rs1_addr != '0) && (exm_rd_addr == ent.rs1_addr);
   assign fwd2     = exm_wr && (ent.rs2_addr != '0) && (exm_rd_addr == ent.rs2_addr);

   assign rs1_eff  = fwd1 ? exm_result : ent.rs1_data;
   assign rs2_eff  = fwd2 ? exm_result : ent.rs2_data;

   // rs2 always counts as used since it also feeds the store data path.
   assign load_hazard = exm_is_load && ((fwd1 && !ent.src_a) || fwd2);

   assign out_valid = v && !load_hazard;
   assign retire    = out_valid && out_ready;
   assign in_ready  = !v || retire;
   assign capture   = in_valid && in_ready;
   assign code_ok   = legal_code(in_alu_ctrl);

   // Build the entry to be captured, applying x0 zeroing, WB bypass and illegal-code squash.
   always_comb begin
      cap           = '0;
      cap.pc        = in_pc;
      cap.imm       = in_imm;
      cap.rs1_addr  = in_rs1_addr;
      cap.rs2_addr  = in_rs2_addr;
      cap.rd_addr   = in_rd_addr;
      cap.src_a     = in_src_a;
      cap.src_b     = in_src_b;
      cap.reg_write = in_reg_write;
      cap.alu_ctrl  = code_ok ? in_alu_ctrl : 4'b0000;
      cap.illegal   = !code_ok;
      if (in_rs1_addr == '0)
         cap.rs1_data = '0;
      else
         cap.rs1_data = cap_wb1 ? wb_data : in_rs1_data;
      if (in_rs2_addr == '0)
         cap.rs2_data = '0;
      else
         cap.rs2_data = cap_wb2 ? wb_data : in_rs2_data;
   end

   // Entry register: reset > flush > capture > retire > WB snoop while held.
   always_ff @(posedge clk) begin
      if (rst) begin
         v   <= 1'b0;
         ent <= '0;
      end else if (flush) begin
         v <= 1'b0;
      end else if (capture) begin
         v   <= 1'b1;
         ent <= cap;
      end else if (retire) begin
         v <= 1'b0;
      end else if (v) begin
         if (hold_wb1) ent.rs1_data <= wb_data;
         if (hold_wb2) ent.rs2_data <= wb_data;
      end
   end

   assign out_op_a       = ent.src_a ? ent.pc  : rs1_eff;
   assign out_op_b       = ent.src_b ? ent.imm : rs2_eff;
   assign out_store_data = rs2_eff;
   assign out_alu_ctrl   = ent.alu_ctrl;
   assign out_pc         = ent.pc;
   assign out_rd_addr    = ent.rd_addr;
   assign out_reg_write  = ent.reg_write && v;
   assign out_illegal    = ent.illegal && v;

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, in_ready;
   logic [31:0] in_pc, in_rs1_data, in_rs2_data, in_imm;
   logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
   logic        in_src_a, in_src_b, in_reg_write;
   logic [3:0]  in_alu_ctrl;
   logic        exm_valid, exm_reg_write, exm_is_load;
   logic [4:0]  exm_rd_addr;
   logic [31:0] exm_result;
   logic        wb_valid, wb_reg_write;
   logic [4:0]  wb_rd_addr;
   logic [31:0] wb_data;
   logic        out_valid, out_ready;
   logic [31:0] out_op_a, out_op_b, out_store_data, out_pc;
   logic [3:0]  out_alu_ctrl;
   logic [4:0]  out_rd_addr;
   logic        out_reg_write, out_illegal;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   alu_issue_stage #(.XLEN(32), .RADDR(5)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
      .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
      .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
      .in_imm(in_imm), .in_src_a(in_src_a), .in_src_b(in_src_b),
      .in_alu_ctrl(in_alu_ctrl), .in_rd_addr(in_rd_addr), .in_reg_write(in_reg_write),
      .exm_valid(exm_valid), .exm_reg_write(exm_reg_write), .exm_is_load(exm_is_load),
      .exm_rd_addr(exm_rd_addr), .exm_result(exm_result),
      .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_rd_addr(wb_rd_addr), .wb_data(wb_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_op_a(out_op_a), .out_op_b(out_op_b), .out_alu_ctrl(out_alu_ctrl),
      .out_store_data(out_store_data), .out_pc(out_pc), .out_rd_addr(out_rd_addr),
      .out_reg_write(out_reg_write), .out_illegal(out_illegal)
   );

   // Reference model: the held instruction as plain values.
   logic        m_v;
   logic [31:0] m_pc, m_imm, m_r1, m_r2;
   logic [4:0]  m_a1, m_a2, m_rd;
   logic        m_sa, m_sb, m_rw, m_ill;
   logic [3:0]  m_op;
   logic        e_valid, e_ready;
   logic [31:0] e_a, e_b, e_sd;
   logic [3:0]  legal_codes [10] = '{4'h0, 4'h8, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'hD, 4'h6, 4'h7};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic writes(input logic vld, input logic rw, input logic [4:0] rd, input logic [4:0] src);
      return vld && rw && (src != 0) && (rd == src);
   endfunction

   function automatic logic [31:0] read_src(input logic [4:0] a, input logic [31:0] rf);
      if (a == 0) return 32'h0;
      if (writes(wb_valid, wb_reg_write, wb_rd_addr, a)) return wb_data;
      return rf;
   endfunction

   task automatic model_eval();
      logic f1, f2;
      f1 = writes(exm_valid, exm_reg_write, exm_rd_addr, m_a1);
      f2 = writes(exm_valid, exm_reg_write, exm_rd_addr, m_a2);
      e_a = m_sa ? m_pc : (f1 ? exm_result : m_r1);
      e_sd = f2 ? exm_result : m_r2;
      e_b = m_sb ? m_imm : e_sd;
      e_valid = m_v && !(exm_is_load && ((f1 && !m_sa) || f2));
      e_ready = !m_v || (e_valid && out_ready);
   endtask

   task automatic model_check();
      model_eval();
      chk("out_valid", out_valid, e_valid);
      chk("in_ready", in_ready, e_ready);
      chk("out_reg_write", out_reg_write, m_v && m_rw);
      chk("out_illegal", out_illegal, m_v && m_ill);
      if (e_valid) begin
         chk("op_a", out_op_a, e_a);
         chk("op_b", out_op_b, e_b);
         chk("store_data", out_store_data, e_sd);
         chk("alu_ctrl", out_alu_ctrl, m_op);
         chk("pc", out_pc, m_pc);
         chk("rd_addr", out_rd_addr, m_rd);
      end
   endtask

   task automatic model_update();
      logic legal, retire;
      model_eval();
      retire = e_valid && out_ready;
      if (rst) begin
         {m_v, m_pc, m_imm, m_r1, m_r2, m_a1, m_a2, m_rd, m_sa, m_sb, m_rw, m_ill, m_op} = '0;
      end else if (flush) begin
         m_v = 1'b0;
      end else if (in_valid && e_ready) begin
         legal = 1'b0;
         foreach (legal_codes[i]) if (legal_codes[i] == in_alu_ctrl) legal = 1'b1;
         m_v = 1'b1; m_pc = in_pc; m_imm = in_imm;
         m_a1 = in_rs1_addr; m_a2 = in_rs2_addr; m_rd = in_rd_addr;
         m_r1 = read_src(in_rs1_addr, in_rs1_data);
         m_r2 = read_src(in_rs2_addr, in_rs2_data);
         m_sa = in_src_a; m_sb = in_src_b; m_rw = in_reg_write;
         m_op = legal ? in_alu_ctrl : 4'h0;
         m_ill = !legal;
      end else if (retire) begin
         m_v = 1'b0;
      end else if (m_v) begin
         m_r1 = read_src(m_a1, m_r1);
         m_r2 = read_src(m_a2, m_r2);
      end
   endtask

   // Inputs are set just after a falling edge; checks land 1 time unit later.
   task automatic cyc();
      #1;
      model_check();
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic clear_in();
      flush = 0; in_valid = 0; in_pc = 0; in_rs1_addr = 0; in_rs2_addr = 0;
      in_rs1_data = 0; in_rs2_data = 0; in_imm = 0; in_src_a = 0; in_src_b = 0;
      in_alu_ctrl = 0; in_rd_addr = 0; in_reg_write = 0;
      exm_valid = 0; exm_reg_write = 0; exm_is_load = 0; exm_rd_addr = 0; exm_result = 0;
      wb_valid = 0; wb_reg_write = 0; wb_rd_addr = 0; wb_data = 0; out_ready = 0;
   endtask

   task automatic reset_outputs_check(input string tag);
      #1;
      chk({tag, "_valid"}, out_valid, 1'b0);
      chk({tag, "_op_a"}, out_op_a, 32'h0);
      chk({tag, "_op_b"}, out_op_b, 32'h0);
      chk({tag, "_ctrl"}, out_alu_ctrl, 4'h0);
      chk({tag, "_rd"}, out_rd_addr, 5'h0);
      chk({tag, "_rw"}, out_reg_write, 1'b0);
      chk({tag, "_ill"}, out_illegal, 1'b0);
      chk({tag, "_ready"}, in_ready, 1'b1);
   endtask

   initial begin
      clear_in();
      rst = 1;
      {m_v, m_pc, m_imm, m_r1, m_r2, m_a1, m_a2, m_rd, m_sa, m_sb, m_rw, m_ill, m_op} = '0;
      @(negedge clk);
      cyc(); cyc();
      rst = 0;
      reset_outputs_check("rst");
      cyc();

      // Basic issue followed by a back-to-back SUB.
      in_valid = 1; in_rs1_addr = 1; in_rs1_data = 5; in_rs2_addr = 2; in_rs2_data = 7;
      in_rd_addr = 3; in_reg_write = 1; in_pc = 32'h100; out_ready = 1;
      cyc();
      in_alu_ctrl = 4'b1000; in_rs1_data = 9; in_rs2_data = 4; in_pc = 32'h104;
      #1;
      chk("basic_a", out_op_a, 5); chk("basic_b", out_op_b, 7); chk("basic_ctrl", out_alu_ctrl, 0);
      cyc();
      in_valid = 0;
      #1;
      chk("b2b_valid", out_valid, 1); chk("b2b_ctrl", out_alu_ctrl, 4'b1000);
      cyc();

      // EX/MEM forward on a held rs1, then rs1 = x0.
      clear_in();
      in_valid = 1; in_rs1_addr = 3; in_rs1_data = 1;
      cyc();
      in_valid = 0; exm_valid = 1; exm_reg_write = 1; exm_rd_addr = 3; exm_result = 32'hDEADBEEF;
      #1 chk("fwd_a", out_op_a, 32'hDEADBEEF);
      cyc();
      out_ready = 1; exm_valid = 0;
      cyc();
      in_valid = 1; in_rs1_addr = 0; in_rs1_data = 32'h1234; out_ready = 0;
      exm_valid = 1; exm_rd_addr = 0;
      cyc();
      in_valid = 0;
      #1 chk("x0_a", out_op_a, 0);
      out_ready = 1;
      cyc();

      // Load-use stall on rs2, resolved by WB snoop.
      clear_in();
      in_valid = 1; in_rs1_addr = 5; in_rs1_data = 3; in_rs2_addr = 4; in_rs2_data = 32'h77; out_ready = 1;
      cyc();
      in_rs1_addr = 6; exm_valid = 1; exm_reg_write = 1; exm_is_load = 1; exm_rd_addr = 4;
      #1;
      chk("lu_valid", out_valid, 0); chk("lu_ready", in_ready, 0);
      cyc();
      in_valid = 0; exm_valid = 0; exm_is_load = 0; out_ready = 0;
      wb_valid = 1; wb_reg_write = 1; wb_rd_addr = 4; wb_data = 32'h40;
      cyc();
      wb_valid = 0; out_ready = 1;
      #1;
      chk("lu_valid2", out_valid, 1); chk("lu_b", out_op_b, 32'h40);
      cyc();

      // Backpressure with WB snoop into rs1.
      clear_in();
      in_valid = 1; in_rs1_addr = 1; in_rs1_data = 32'h11;
      cyc();
      in_rs1_addr = 2; wb_valid = 1; wb_reg_write = 1; wb_rd_addr = 1; wb_data = 32'h99;
      #1 chk("bp_ready", in_ready, 0);
      cyc();
      wb_valid = 0;
      cyc();
      #1 chk("bp_a", out_op_a, 32'h99);
      cyc();
      out_ready = 1;
      cyc();
      in_valid = 0;
      cyc();

      // Flush drops an accepted instruction; illegal code squashed to ADD.
      clear_in();
      out_ready = 1; in_valid = 1; in_reg_write = 1; in_rd_addr = 7; flush = 1;
      #1 chk("fl_ready", in_ready, 1);
      cyc();
      flush = 0; in_valid = 0;
      #1;
      chk("fl_valid", out_valid, 0); chk("fl_rw", out_reg_write, 0);
      cyc();
      in_valid = 1; in_alu_ctrl = 4'b1001;
      cyc();
      in_valid = 0;
      #1;
      chk("ill_ctrl", out_alu_ctrl, 0); chk("ill_flag", out_illegal, 1);
      cyc();

      // Reset while a load-use stall holds.
      clear_in();
      in_valid = 1; in_rs2_addr = 4; in_rs2_data = 32'h55; in_rd_addr = 9; in_reg_write = 1;
      in_alu_ctrl = 4'b0110; in_pc = 32'h200; out_ready = 1;
      cyc();
      in_valid = 0; exm_valid = 1; exm_reg_write = 1; exm_is_load = 1; exm_rd_addr = 4;
      #1 chk("rs_stall", out_valid, 0);
      rst = 1;
      cyc();
      rst = 0;
      clear_in();
      reset_outputs_check("rst2");
      cyc();

      // Randomized traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         rst = ($urandom_range(0, 127) == 0);
         flush = ($urandom_range(0, 15) == 0);
         in_valid = $urandom_range(0, 1);
         in_pc = $urandom; in_imm = $urandom;
         in_rs1_addr = 5'($urandom_range(0, 3)); in_rs2_addr = 5'($urandom_range(0, 3));
         in_rs1_data = $urandom; in_rs2_data = $urandom;
         in_src_a = $urandom_range(0, 1); in_src_b = $urandom_range(0, 1);
         in_alu_ctrl = 4'($urandom_range(0, 15));
         in_rd_addr = 5'($urandom_range(0, 31)); in_reg_write = $urandom_range(0, 1);
         exm_valid = $urandom_range(0, 1); exm_reg_write = $urandom_range(0, 1);
         exm_is_load = ($urandom_range(0, 3) == 0);
         exm_rd_addr = 5'($urandom_range(0, 3)); exm_result = $urandom;
         wb_valid = $urandom_range(0, 1); wb_reg_write = $urandom_range(0, 1);
         wb_rd_addr = 5'($urandom_range(0, 3)); wb_data = $urandom;
         out_ready = ($urandom_range(0, 3) != 0);
         cyc();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- ID/EX pipeline stage. Holds one decoded instruction and drives the ALU's two 32-bit operands and its 4-bit operation code.
- Resolves RAW hazards: write-back snooping into the held entry, combinational EX/MEM forwarding at the output, and load-use stall.
- Sits between decode/regfile read and the ALU. Uses a valid/ready handshake on both sides, plus a synchronous flush for branch redirects.

Parameters:
- XLEN, 32, datapath width of operands, results and PC.
- RADDR, 5, register address width.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- flush  in  1  discard held/incoming instruction (branch redirect).
- in_valid  in  1  decode has an instruction.
- in_ready  out  1  stage can accept this cycle.
- in_pc  in  XLEN  instruction PC.
- in_rs1_addr, in_rs2_addr  in  RADDR  source registers.
- in_rs1_data, in_rs2_data  in  XLEN  regfile read data.
- in_imm  in  XLEN  sign-extended immediate.
- in_src_a  in  1  0: rs1, 1: PC as operand A.
- in_src_b  in  1  0: rs2, 1: imm as operand B.
- in_alu_ctrl  in  4  ALU operation code.
- in_rd_addr  in  RADDR  destination register.
- in_reg_write  in  1  instruction writes rd.
- exm_valid, exm_reg_write, exm_is_load  in  1 each  EX/MEM entry status.
- exm_rd_addr  in  RADDR  EX/MEM destination.
- exm_result  in  XLEN  EX/MEM ALU result.
- wb_valid, wb_reg_write  in  1 each  write-back status.
- wb_rd_addr  in  RADDR  write-back destination.
- wb_data  in  XLEN  write-back data.
- out_valid  out  1  operands valid for the ALU.
- out_ready  in  1  EX stage consumes this cycle.
- out_op_a, out_op_b  out  XLEN  ALU operands.
- out_alu_ctrl  out  4  ALU operation code.
- out_store_data  out  XLEN  forwarded rs2 value.
- out_pc  out  XLEN  held PC.
- out_rd_addr  out  RADDR  held destination.
- out_reg_write  out  1  held reg_write AND held valid.
- out_illegal  out  1  held alu_ctrl was not a legal code.

Behaviour:
- Storage: a single entry with valid bit v.
- Handshake and capture:
  - in_ready = !v || (out_valid && out_ready), combinational.
  - Capture when in_valid && in_ready.
  - Entry retires when out_valid && out_ready; a simultaneous capture refills the entry, so zero-bubble throughput is 1/cycle.
- Legal ALU codes: 0000 ADD, 1000 SUB, 0001 SLL, 0010 SLT, 0011 SLTU, 0100 XOR, 0101 SRL, 1101 SRA, 0110 OR, 0111 AND.
  - Any other code is stored as 0000 and sets the held illegal flag.
  - out_illegal = flag && v.
- x0: a source address of 0 stores data 0 and never matches any forward or snoop.
- Capture-time bypass: if wb_valid && wb_reg_write && wb_rd_addr == src addr (non-zero), store wb_data instead of the in_*_data value.
- Hold-time snoop: every cycle with v=1 and no retire, the same WB match overwrites the stored rs1/rs2 data with wb_data.
- Output forwarding, combinational, per source:
  - Condition: exm_valid && exm_reg_write && exm_rd_addr == src (non-zero).
  - Condition true: rs_eff = exm_result.
  - Condition false: rs_eff = stored data.
  - EX/MEM has priority over stored/WB data.
- Load-use stall:
  - If the EX/MEM match holds and exm_is_load=1 for an operand actually used, force out_valid=0 and hold.
  - An operand is used when its src_* bit is 0; for rs2, also when it feeds out_store_data. Treat rs2 as always used.
- Operand selection:
  - out_op_a = src_a ? pc : rs1_eff.
  - out_op_b = src_b ? imm : rs2_eff.
  - out_store_data = rs2_eff.
- out_valid = v && !load_hazard. Operand outputs are meaningful only when out_valid=1.
- Flush:
  - Next cycle v=0.
  - Flush wins over a same-cycle capture: the instruction is accepted (in_ready unaffected) and dropped.
  - Flush during a stall also clears the entry.
- Reset:
  - Sets v=0 and clears all stored fields to 0.
  - Outputs after reset: out_valid=0, out_op_a=0, out_op_b=0, out_alu_ctrl=0000, out_rd_addr=0, out_reg_write=0, out_illegal=0, in_ready=1.
  - Reset overrides flush and capture; an instruction mid-stall is lost.
- Latency: 1 cycle from capture to out_valid when there is no hazard.

Test Plan:
- Basic issue: capture ADD, rs1=x1 (data 5), rs2=x2 (data 7), src 0/0 → next cycle out_valid=1, op_a=5, op_b=7, alu_ctrl=0000; with out_ready=1 and a back-to-back SUB, out_valid stays 1 and alu_ctrl=1000.
- EX/MEM forward: held rs1=x3 (stored 1), exm_valid=1, reg_write=1, rd=3, result=0xDEAD_BEEF → op_a=0xDEADBEEF; same with rs1=x0 → op_a=0.
- Load-use: exm_is_load=1, rd=x4 matches rs2, src_b=0 → out_valid=0, in_ready=0. Next cycle the load arrives on WB with data 0x40 and EX/MEM is clear → out_valid=1, op_b=0x40.
- Backpressure snoop: out_ready=0 for 3 cycles, WB writes x1=0x99 during the hold → op_a becomes 0x99; new in_valid is held off (in_ready=0).
- Flush: flush=1 with in_valid=1 and in_ready=1 → next cycle out_valid=0, out_reg_write=0. Illegal code 1001 captured → out_alu_ctrl=0000, out_illegal=1.
- Reset mid-stall: rst=1 while a load hazard holds → next cycle out_valid=0, all outputs 0, in_ready=1.
